fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side controller for the 16-stage, 8-bit synchronous FIFO. It issues the FIFO read strobe and drains entries into a downstream valid/ready stream.
- Drains in fixed bursts of BURST_LEN once the FIFO threshold flag is raised (at least 8 entries stored).
- If data sits below threshold for TIMEOUT cycles, it flushes the remainder as single-beat bursts.
- Sits between the FIFO and the consumer.

Parameters:
- DATA_W, 8: data width; must match the FIFO.
- BURST_LEN, 8: beats per threshold-triggered burst; must be ≤ 8 so a burst never underflows the FIFO.
- TIMEOUT, 16: cycles in WAIT before a partial flush starts; ≥ 1.
- TMR_W, $clog2(TIMEOUT)+1: timeout counter width.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- en, in, 1: enables new drain activity.
- fifo_data, in, DATA_W: FIFO data_out. Combinational, first-word-fall-through: shows the head entry while fifo_empty=0.
- fifo_empty, in, 1: FIFO is_empty.
- fifo_threshold, in, 1: FIFO threshold (occupancy ≥ 8).
- fifo_read, out, 1: FIFO read strobe. Pops the head entry at the next rising edge.
- m_data, out, DATA_W: downstream data (registered).
- m_valid, out, 1: downstream valid.
- m_ready, in, 1: downstream ready.
- m_last, out, 1: marks the final beat of a burst.
- busy, out, 1: high in any state other than IDLE.
- err, out, 1: sticky flag; FIFO went empty while a burst still had beats outstanding.

Behaviour:
- Reset (async, immediate): state=IDLE, fifo_read=0, m_valid=0, m_last=0, m_data=0, err=0, timer=0, beats_left=0.
- fifo_read is combinational: state∈{BURST,SINGLE} && beats_left≠0 && !fifo_empty && (!m_valid || m_ready). It is never asserted while fifo_empty=1.
- Output register, one entry:
  - On a read: m_data<=fifo_data, m_valid<=1, m_last<=(beats_left==1), beats_left--.
  - Else if m_valid && m_ready: m_valid<=0, m_last<=0.
  - Latency is 1 cycle from fifo_read to m_valid. Throughput is 1 beat/cycle with m_ready held high.
- m_data/m_last stay stable while m_valid && !m_ready (AXI-style hold). No beat is dropped or duplicated.
- FSM:
  - IDLE: if en && !fifo_empty -> WAIT, timer<=0.
  - WAIT:
    - fifo_threshold=1 -> BURST, beats_left<=BURST_LEN.
    - else fifo_empty=1 -> IDLE.
    - else timer==TIMEOUT-1 -> SINGLE, beats_left<=1.
    - else timer++.
    - If en=0 in WAIT -> IDLE.
  - BURST: reads as allowed. When the read with beats_left==1 fires -> IDLE. If fifo_empty=1 while beats_left≠0: set err=1 and go to IDLE. The burst is truncated and m_last is not generated for it.
  - SINGLE:
    - Each beat is its own burst with m_last=1. After each read, reload beats_left<=1.
    - In a cycle with no read: fifo_threshold=1 -> BURST (beats_left<=BURST_LEN); else fifo_empty=1 -> IDLE.
    - en=0 -> IDLE after any pending read completes. The output register drains independently of the state.
- en is evaluated only at state decisions. A started BURST always completes even if en drops.
- Reading while the FIFO's writer is active is allowed. The FIFO's simultaneous read/write is handled by the FIFO itself; this block relies on fifo_empty/fifo_threshold only.
- Timer saturates and never wraps. beats_left is width $clog2(BURST_LEN)+1.
- The reader never creates FIFO underflow: the FIFO underflow flag must stay 0 under all legal stimulus.

Decomposition:
- Shared package fifo_pkg:
  - FSM state enum: IDLE, WAIT, BURST, SINGLE.
  - FIFO_DEPTH=16, FIFO_DATA_W=8, FIFO_THRESH=8.
- One natural sub-module: fifo_out_reg, the 1-entry valid/ready output register with load/accept logic. The FSM and counters stay in the top.

Test Plan:
1. Reset: hold rst_n=0 with FIFO full -> fifo_read=0, m_valid=0, m_last=0, err=0, busy=0. Assert rst_n mid-burst -> m_valid falls asynchronously, same cycle.
2. Full burst: preload 0x10..0x17, m_ready=1, en=1 -> fifo_read high exactly 8 consecutive cycles. m_data = 0x10..0x17 on consecutive cycles, m_last only with 0x17, then IDLE. FIFO is_empty=1, underflow=0.
3. Backpressure: preload 0x20..0x27, m_ready pattern 1,0,0,1,0,1... -> every value received exactly once in order. No fifo_read while m_valid && !m_ready. Data held stable while stalled.
4. Timeout flush: TIMEOUT=16, write 0xA1,0xA2,0xA3 -> no fifo_read for 16 cycles after non-empty. Then three beats, each with m_last=1, then IDLE with busy=0.
5. Promotion: in SINGLE after 0xB0, burst-write 8 more entries -> switch to BURST. Next 8 beats have m_last only on the 8th. Concurrent FIFO writes never raise FIFO overflow.
6. Enable gating: en=0 with 10 entries -> no fifo_read, busy=0. Raise en -> BURST of 8 starts within 3 cycles. Drop en mid-burst -> burst still completes all 8 beats.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 16x8 FIFO and its burst read-side controller.
package fifo_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_THRESH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    BURST  = 2'd2,
    SINGLE = 2'd3
  } rd_state_e;

  // States in which the controller may pop the FIFO.
  function automatic logic is_draining(input rd_state_e st);
    return (st == BURST) || (st == SINGLE);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read side plus downstream valid/ready stream of the burst reader.
interface fifo_burst_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);

  logic              en;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_threshold;
  logic              fifo_read;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              err;

  modport master (
    input  en,
    input  fifo_data,
    input  fifo_empty,
    input  fifo_threshold,
    output fifo_read,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    output busy,
    output err
  );

  modport slave (
    output en,
    output fifo_data,
    output fifo_empty,
    output fifo_threshold,
    input  fifo_read,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    input  busy,
    input  err
  );

endinterface

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output stage: a load captures a beat, an accept empties it.
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  // Load has priority; the upstream only loads when the slot is free or being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= r_valid;
      r_last  <= r_last;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side FIFO controller: drains fixed bursts on threshold, flushes
// leftovers as single-beat bursts after a below-threshold timeout.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16,
  parameter int TMR_W     = $clog2(TIMEOUT) + 1
) (
  input  logic clk,
  input  logic rst_n,
  fifo_burst_reader_if.master bus
);

  localparam int BL_W = $clog2(BURST_LEN) + 1;
  localparam logic [BL_W-1:0]  BL_LOAD  = BL_W'(BURST_LEN);
  localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [BL_W-1:0]   r_beats_left;
  logic [BL_W-1:0]   w_beats_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_busy;

  logic              w_read;
  logic              w_out_free;
  logic              w_last_beat;
  logic [DATA_W-1:0] w_m_data;
  logic              w_m_valid;
  logic              w_m_last;

  // A pop is only issued when the output slot will be free at the same edge.
  assign w_out_free  = !w_m_valid || bus.m_ready;
  assign w_last_beat = (r_beats_left == BL_ONE);
  assign w_read      = is_draining(r_state) && (r_beats_left != '0) &&
                       !bus.fifo_empty && w_out_free;

  // Next-state, timer, beat counter and sticky error.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_beats_nxt = r_beats_left;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (bus.en && !bus.fifo_empty) begin
          w_state_nxt = WAIT;
          w_timer_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!bus.en) begin
          w_state_nxt = IDLE;
        end else if (bus.fifo_threshold) begin
          w_state_nxt = BURST;
          w_beats_nxt = BL_LOAD;
        end else if (bus.fifo_empty) begin
          w_state_nxt = IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_state_nxt = SINGLE;
          w_beats_nxt = BL_ONE;
        end else if (r_timer < TMR_LAST) begin
          w_timer_nxt = r_timer + TMR_ONE;
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      BURST: begin
        if (w_read) begin
          w_beats_nxt = r_beats_left - BL_ONE;
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = BURST;
          end
        end else if (bus.fifo_empty) begin
          // Truncated burst: no m_last is produced for it.
          w_err_nxt   = 1'b1;
          w_beats_nxt = '0;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BURST;
        end
      end
      SINGLE: begin
        if (w_read) begin
          w_beats_nxt = BL_ONE;
          if (bus.en) begin
            w_state_nxt = SINGLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (bus.fifo_threshold && bus.en) begin
          w_state_nxt = BURST;
          w_beats_nxt = BL_LOAD;
        end else if (bus.fifo_empty) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SINGLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_beats_nxt = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_beats_left <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_beats_left <= w_beats_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  fifo_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_read),
    .i_data  (bus.fifo_data),
    .i_last  (w_last_beat),
    .i_ready (bus.m_ready),
    .o_data  (w_m_data),
    .o_valid (w_m_valid),
    .o_last  (w_m_last)
  );

  assign bus.fifo_read = w_read;
  assign bus.m_data    = w_m_data;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_last    = w_m_last;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO environment, directed table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int BL = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.DATA_W(DW)) bus ();

  fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural 16x8 FWFT FIFO that the reader drains.
  logic [7:0] fmem [16];
  logic [4:0] fcnt;
  logic [3:0] frp, fwp;
  logic       fovf, fudf;
  logic       wr_en, env_clr;
  logic [7:0] wr_data;
  wire        w_pop  = bus.fifo_read && (fcnt != 5'd0);
  wire        w_push = wr_en && ((fcnt != 5'd16) || w_pop);

  assign bus.fifo_data      = fmem[frp];
  assign bus.fifo_empty     = (fcnt == 5'd0);
  assign bus.fifo_threshold = (fcnt >= 5'd8);

  always @(posedge clk) begin
    if (env_clr) begin
      frp <= 4'd0; fwp <= 4'd0; fcnt <= 5'd0; fovf <= 1'b0; fudf <= 1'b0;
    end else begin
      if (w_push) begin
        fmem[fwp] <= wr_data;
        fwp <= fwp + 4'd1;
      end
      if (w_pop) frp <= frp + 4'd1;
      fcnt <= fcnt + {4'd0, w_push} - {4'd0, w_pop};
      if (bus.fifo_read && fcnt == 5'd0) fudf <= 1'b1;
      if (wr_en && !w_push) fovf <= 1'b1;
    end
  end

  // Bench bookkeeping
  int n_tot = 0, n_pass = 0;
  logic [15:0] ready_pat;
  logic        ready_rand, mon_clr;
  int          ridx;

  logic [7:0] got_d [$];
  bit         got_l [$];
  int rd_cnt, cur_run, max_run, first_rd, tick_n, viol_rd, viol_hold, grp_len, grp_bad;
  bit prev_stall, prev_l;
  logic [7:0] prev_d;

  // Monitor: samples 1 time unit after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_clr) begin
        got_d.delete(); got_l.delete();
        rd_cnt = 0; cur_run = 0; max_run = 0; first_rd = -1; tick_n = 0;
        viol_rd = 0; viol_hold = 0; grp_len = 0; grp_bad = 0; prev_stall = 1'b0;
      end
      if (prev_stall && (!bus.m_valid || bus.m_data != prev_d || bus.m_last != prev_l)) viol_hold++;
      if (bus.fifo_read && bus.m_valid && !bus.m_ready) viol_rd++;
      if (bus.fifo_read) begin
        rd_cnt++; cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (first_rd < 0) first_rd = tick_n;
      end else begin
        cur_run = 0;
      end
      if (bus.m_valid && bus.m_ready) begin
        got_d.push_back(bus.m_data);
        got_l.push_back(bus.m_last);
        grp_len++;
        if (bus.m_last) begin
          if (grp_len != 1 && grp_len != BL) grp_bad++;
          grp_len = 0;
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d = bus.m_data;
      prev_l = bus.m_last;
      tick_n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_tot++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic tick(input logic we = 1'b0, input logic [7:0] d = 8'h00, input logic clr = 1'b0);
    @(negedge clk);
    wr_en = we; wr_data = d; mon_clr = clr;
    if (clr) ridx = 0;
    if (ready_rand) bus.m_ready = ($urandom_range(0, 99) < 70);
    else bus.m_ready = ready_pat[ridx];
    ridx = (ridx + 1) % 16;
  endtask

  task automatic wait_done(input int n, input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      #2;
      if (got_d.size() >= n && !bus.busy && !bus.m_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      #2;
      if (bus.m_valid) ok = 1'b1;
    end
  endtask

  task automatic chk_proto(input string nm);
    chk({nm, "_read_while_stalled"}, viol_rd, 0);
    chk({nm, "_hold_stable"}, viol_hold, 0);
    chk({nm, "_underflow"}, fudf, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  base;
    int          n;
    logic [15:0] rp;
    logic [15:0] lm;
    int          fmin;
    int          fmax;
    int          run;
  } vec_t;

  vec_t vt [5];
  logic ok;
  logic [7:0] exp_q [$];
  int bad, wprob;

  initial begin
    vt[0] = '{base: 8'h10, n: 8,  rp: 16'hFFFF, lm: 16'h0080, fmin: 1,  fmax: 3,  run: 8};
    vt[1] = '{base: 8'h20, n: 8,  rp: 16'hB369, lm: 16'h0080, fmin: 1,  fmax: 3,  run: 0};
    vt[2] = '{base: 8'hA1, n: 3,  rp: 16'hFFFF, lm: 16'h0007, fmin: 16, fmax: 20, run: 3};
    vt[3] = '{base: 8'h40, n: 10, rp: 16'hFFFF, lm: 16'h0380, fmin: 1,  fmax: 3,  run: 8};
    vt[4] = '{base: 8'h50, n: 1,  rp: 16'hFFFF, lm: 16'h0001, fmin: 16, fmax: 20, run: 1};

    rst_n = 1'b0; env_clr = 1'b1; wr_en = 1'b0; wr_data = 8'h00; mon_clr = 1'b1;
    ready_rand = 1'b0; ready_pat = 16'hFFFF; ridx = 0;
    bus.en = 1'b1; bus.m_ready = 1'b1;
    tick(); tick();
    env_clr = 1'b0;

    // Reset held with a full FIFO and en high
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(i));
    tick(); tick(); #2;
    chk("rst_fifo_full", fcnt, 16);
    chk("rst_fifo_read", bus.fifo_read, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_m_data", bus.m_data, 8'h00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    tick(); bus.en = 1'b0; rst_n = 1'b1; env_clr = 1'b1;
    tick(); env_clr = 1'b0;

    // Directed table: preload with en low, then enable and collect
    for (int v = 0; v < 5; v++) begin
      ready_rand = 1'b0; ready_pat = vt[v].rp; bus.en = 1'b0;
      for (int i = 0; i < vt[v].n; i++) tick(1'b1, vt[v].base + 8'(i));
      tick(1'b0, 8'h00, 1'b1);
      bus.en = 1'b1;
      wait_done(vt[v].n, 300, ok);
      chk($sformatf("v%0d_done", v), ok, 1'b1);
      chk($sformatf("v%0d_beats", v), got_d.size(), vt[v].n);
      for (int i = 0; i < got_d.size(); i++) begin
        chk($sformatf("v%0d_data%0d", v, i), got_d[i], vt[v].base + 8'(i));
        chk($sformatf("v%0d_last%0d", v, i), got_l[i], vt[v].lm[i]);
      end
      chk($sformatf("v%0d_reads", v), rd_cnt, vt[v].n);
      chk_rng($sformatf("v%0d_first_read", v), first_rd, vt[v].fmin, vt[v].fmax);
      if (vt[v].run != 0) chk($sformatf("v%0d_read_run", v), max_run, vt[v].run);
      chk($sformatf("v%0d_fifo_empty", v), bus.fifo_empty, 1'b1);
      chk_proto($sformatf("v%0d", v));
    end

    // Promotion from SINGLE to BURST while the output is stalled
    ready_pat = 16'h0000; bus.en = 1'b0;
    tick(1'b1, 8'hB0); tick(1'b1, 8'hB1);
    tick(1'b0, 8'h00, 1'b1);
    bus.en = 1'b1;
    wait_valid(40, ok);
    chk("promo_first_single", ok, 1'b1);
    for (int i = 2; i < 10; i++) tick(1'b1, 8'hB0 + 8'(i));
    ready_pat = 16'hFFFF;
    wait_done(10, 200, ok);
    chk("promo_done", ok, 1'b1);
    chk("promo_beats", got_d.size(), 10);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("promo_data%0d", i), got_d[i], 8'hB0 + 8'(i));
      chk($sformatf("promo_last%0d", i), got_l[i], (i == 0 || i == 8 || i == 9));
    end
    chk("promo_overflow", fovf, 1'b0);
    chk_proto("promo");

    // Enable gating: no activity with en low, burst survives en dropping
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b1, 8'h60 + 8'(i));
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    #2;
    chk("gate_no_read", rd_cnt, 0);
    chk("gate_idle", bus.busy, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    bus.en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick(); #2;
      if (got_d.size() >= 3) ok = 1'b1;
    end
    chk("gate_started", ok, 1'b1);
    tick(); bus.en = 1'b0;
    wait_done(8, 100, ok);
    chk("gate_done", ok, 1'b1);
    chk_rng("gate_first_read", first_rd, 1, 3);
    chk("gate_beats", got_d.size(), 8);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("gate_data%0d", i), got_d[i], 8'h60 + 8'(i));
      chk($sformatf("gate_last%0d", i), got_l[i], (i == 7));
    end
    chk("gate_left_in_fifo", fcnt, 2);
    tick(1'b0, 8'h00, 1'b1);
    bus.en = 1'b1;
    wait_done(2, 100, ok);
    chk("gate_flush_done", ok, 1'b1);
    chk("gate_flush_beats", got_d.size(), 2);
    chk("gate_flush_last", {31'd0, got_l.size() == 2 && got_l[0] && got_l[1]}, 1);

    // Asynchronous reset in the middle of a burst
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b1, 8'h70 + 8'(i));
    tick(1'b0, 8'h00, 1'b1);
    bus.en = 1'b1;
    wait_valid(20, ok);
    chk("arst_burst_started", ok, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", bus.m_valid, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_fifo_read", bus.fifo_read, 1'b0);
    tick(); rst_n = 1'b1; env_clr = 1'b1; bus.en = 1'b0;
    tick(); env_clr = 1'b0;

    // Randomized traffic against a scoreboard
    ready_rand = 1'b1; bus.en = 1'b1; exp_q.delete(); wprob = 50;
    tick(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 150 == 0) wprob = $urandom_range(0, 100);
      wr_en = (fcnt < 5'd16) && ($urandom_range(0, 99) < wprob);
      wr_data = 8'($urandom);
      if (wr_en) exp_q.push_back(wr_data);
    end
    wait_done(exp_q.size(), 2000, ok);
    chk("rand_drained", ok, 1'b1);
    chk("rand_beats", got_d.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++)
      if (got_d[i] !== exp_q[i]) bad++;
    chk("rand_data_mismatches", bad, 0);
    chk("rand_group_len", grp_bad, 0);
    chk("rand_err", bus.err, 1'b0);
    chk("rand_overflow", fovf, 1'b0);
    chk_proto("rand");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
